// File: rtl/issue_queue_pkg.sv
// issue_queue_pkg: opcode encoding, dispatch classes and the class decoder shared by the issue queue.
package issue_queue_pkg;
    localparam int OP_BITS = 6;
    localparam logic [OP_BITS-1:0] OP_NOP = 6'd0, OP_LUI = 6'd1, OP_AUIPC = 6'd2, OP_JAL = 6'd3, OP_JALR = 6'd4;
    localparam logic [OP_BITS-1:0] OP_BEQ = 6'd5, OP_BNE = 6'd6, OP_BLT = 6'd7, OP_BGE = 6'd8, OP_BLTU = 6'd9, OP_BGEU = 6'd10;
    localparam logic [OP_BITS-1:0] OP_LB = 6'd11, OP_LH = 6'd12, OP_LW = 6'd13, OP_LBU = 6'd14, OP_LHU = 6'd15;
    localparam logic [OP_BITS-1:0] OP_SB = 6'd16, OP_SH = 6'd17, OP_SW = 6'd18;
    localparam logic [OP_BITS-1:0] OP_ADDI = 6'd19, OP_SLTI = 6'd20, OP_SLTIU = 6'd21, OP_XORI = 6'd22, OP_ORI = 6'd23;
    localparam logic [OP_BITS-1:0] OP_ANDI = 6'd24, OP_SLLI = 6'd25, OP_SRLI = 6'd26, OP_SRAI = 6'd27;
    localparam logic [OP_BITS-1:0] OP_ADD = 6'd28, OP_SUB = 6'd29, OP_SLL = 6'd30, OP_SLT = 6'd31, OP_SLTU = 6'd32;
    localparam logic [OP_BITS-1:0] OP_XOR = 6'd33, OP_SRL = 6'd34, OP_SRA = 6'd35, OP_OR = 6'd36, OP_AND = 6'd37;

    typedef enum logic [1:0] {CLS_ALU = 2'd0, CLS_LOAD = 2'd1, CLS_STORE = 2'd2, CLS_BRANCH = 2'd3} op_class_t;

    function automatic op_class_t op_class(input logic [OP_BITS-1:0] op);
        return (op >= OP_LB && op <= OP_LHU) ? CLS_LOAD :
               (op >= OP_SB && op <= OP_SW) ? CLS_STORE :
               (op >= OP_BEQ && op <= OP_BGEU) ? CLS_BRANCH : CLS_ALU;
    endfunction
endpackage

// File: rtl/issue_queue_cdb_match.sv
// cdb_match: looks one operand tag up on all CDB channels; the lowest matching channel supplies the value.
module cdb_match #(
    parameter int CDB_N = 2,
    parameter int DATA_W = 32,
    parameter int ROB_W = 4
) (
    input  logic [ROB_W-1:0]        tag,
    input  logic [CDB_N-1:0]        cdb_valid,
    input  logic [CDB_N*ROB_W-1:0]  cdb_tag,
    input  logic [CDB_N*DATA_W-1:0] cdb_val,
    output logic                    hit,
    output logic [DATA_W-1:0]       val
);
    always_comb begin
        hit = 1'b0;
        val = '0;
        for (int i = CDB_N - 1; i >= 0; i--)
            if (cdb_valid[i] && cdb_tag[i*ROB_W +: ROB_W] == tag) begin
                hit = 1'b1;
                val = cdb_val[i*DATA_W +: DATA_W];
            end
    end
endmodule

// File: rtl/issue_queue.sv
// issue_queue: in-order FIFO between decode and ROB/RS/LSB with CDB operand wakeup and
// one in-order dispatch per cycle.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CDB_N = 2,
    parameter int DATA_W = 32,
    parameter int ROB_W = 4,
    parameter int RS_W = 4,
    parameter int LSB_W = 4,
    parameter int OP_W = 6
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear_in,
    input  logic                    dec_valid,
    output logic                    dec_ready,
    input  logic [OP_W-1:0]         dec_op,
    input  logic [4:0]              dec_rd,
    input  logic [DATA_W-1:0]       dec_imm,
    input  logic [DATA_W-1:0]       dec_pc,
    input  logic [DATA_W-1:0]       dec_pred_pc,
    input  logic                    dec_qj,
    input  logic                    dec_qk,
    input  logic [DATA_W-1:0]       dec_vj,
    input  logic [DATA_W-1:0]       dec_vk,
    input  logic [CDB_N-1:0]        cdb_valid,
    input  logic [CDB_N*ROB_W-1:0]  cdb_tag,
    input  logic [CDB_N*DATA_W-1:0] cdb_val,
    input  logic                    rob_avail,
    input  logic                    rs_avail,
    input  logic                    lsb_avail,
    input  logic [ROB_W-1:0]        rob_avail_pos,
    input  logic [RS_W-1:0]         rs_avail_pos,
    input  logic [LSB_W-1:0]        lsb_avail_pos,
    output logic                    issue_valid,
    output logic [OP_W-1:0]         issue_op,
    output logic [4:0]              issue_rd,
    output logic [DATA_W-1:0]       issue_imm,
    output logic [DATA_W-1:0]       issue_pc,
    output logic [DATA_W-1:0]       issue_pred_pc,
    output logic [DATA_W-1:0]       issue_vj,
    output logic [DATA_W-1:0]       issue_vk,
    output logic                    issue_qj,
    output logic                    issue_qk,
    output logic [ROB_W-1:0]        issue_robpos,
    output logic [RS_W-1:0]         issue_rspos,
    output logic [LSB_W-1:0]        issue_lsbpos,
    output logic                    rob_push,
    output logic                    rs_push,
    output logic                    lsb_push,
    output logic                    lock
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [4:0]        rd;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] pred_pc;
        logic              qj;
        logic [DATA_W-1:0] vj;
        logic              qk;
        logic [DATA_W-1:0] vk;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [AW-1:0]     head, tail;
    logic [AW:0]       count;
    logic [DEPTH-1:0]  hit_j, hit_k;
    logic [DATA_W-1:0] val_j [DEPTH];
    logic [DATA_W-1:0] val_k [DEPTH];
    logic              in_hj, in_hk, hd_hj, hd_hk;
    logic [DATA_W-1:0] in_vj, in_vk, hd_vj, hd_vk;
    entry_t            incoming, h;
    op_class_t         cls;
    logic              to_rs, enq, disp;

    genvar d;
    generate
        for (d = 0; d < DEPTH; d++) begin : g_wake
            cdb_match #(.CDB_N(CDB_N), .DATA_W(DATA_W), .ROB_W(ROB_W)) u_j (
                .tag(mem[d].vj[ROB_W-1:0]), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
                .cdb_val(cdb_val), .hit(hit_j[d]), .val(val_j[d]));
            cdb_match #(.CDB_N(CDB_N), .DATA_W(DATA_W), .ROB_W(ROB_W)) u_k (
                .tag(mem[d].vk[ROB_W-1:0]), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
                .cdb_val(cdb_val), .hit(hit_k[d]), .val(val_k[d]));
        end
    endgenerate

    cdb_match #(.CDB_N(CDB_N), .DATA_W(DATA_W), .ROB_W(ROB_W)) u_in_j (
        .tag(dec_vj[ROB_W-1:0]), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_val(cdb_val), .hit(in_hj), .val(in_vj));
    cdb_match #(.CDB_N(CDB_N), .DATA_W(DATA_W), .ROB_W(ROB_W)) u_in_k (
        .tag(dec_vk[ROB_W-1:0]), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_val(cdb_val), .hit(in_hk), .val(in_vk));
    cdb_match #(.CDB_N(CDB_N), .DATA_W(DATA_W), .ROB_W(ROB_W)) u_hd_j (
        .tag(h.vj[ROB_W-1:0]), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_val(cdb_val), .hit(hd_hj), .val(hd_vj));
    cdb_match #(.CDB_N(CDB_N), .DATA_W(DATA_W), .ROB_W(ROB_W)) u_hd_k (
        .tag(h.vk[ROB_W-1:0]), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_val(cdb_val), .hit(hd_hk), .val(hd_vk));

    always_comb begin
        h = mem[head];
        cls = op_class(h.op);
        to_rs = cls == CLS_ALU || cls == CLS_BRANCH;
        // dec_ready deliberately ignores a same-cycle dispatch to keep it off the back-end timing path
        dec_ready = !rst_in && rdy_in && count != (AW+1)'(DEPTH);
        enq = dec_valid && dec_ready && !clear_in;
        disp = !rst_in && rdy_in && !clear_in && count != '0 && rob_avail && (to_rs ? rs_avail : lsb_avail);
        incoming = '{op: dec_op, rd: dec_rd, imm: dec_imm, pc: dec_pc, pred_pc: dec_pred_pc,
                     qj: dec_qj && !in_hj, vj: (dec_qj && in_hj) ? in_vj : dec_vj,
                     qk: dec_qk && !in_hk, vk: (dec_qk && in_hk) ? in_vk : dec_vk};
    end

    assign issue_valid   = disp;
    assign rob_push      = disp;
    assign rs_push       = disp && to_rs;
    assign lsb_push      = disp && !to_rs;
    assign lock          = disp && (cls == CLS_ALU || cls == CLS_LOAD);
    assign issue_op      = disp ? h.op : '0;
    assign issue_rd      = disp ? h.rd : '0;
    assign issue_imm     = disp ? h.imm : '0;
    assign issue_pc      = disp ? h.pc : '0;
    assign issue_pred_pc = disp ? h.pred_pc : '0;
    assign issue_qj      = disp && h.qj && !hd_hj;
    assign issue_qk      = disp && h.qk && !hd_hk;
    assign issue_vj      = !disp ? '0 : (h.qj && hd_hj) ? hd_vj : h.vj;
    assign issue_vk      = !disp ? '0 : (h.qk && hd_hk) ? hd_vk : h.vk;
    assign issue_robpos  = disp ? rob_avail_pos : '0;
    assign issue_rspos   = disp ? rs_avail_pos : '0;
    assign issue_lsbpos  = disp ? lsb_avail_pos : '0;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].qj <= 1'b0;
                mem[i].qk <= 1'b0;
            end
        end else if (rdy_in) begin
            if (clear_in) begin
                head <= '0;
                tail <= '0;
                count <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem[i].qj && hit_j[i]) begin
                        mem[i].qj <= 1'b0;
                        mem[i].vj <= val_j[i];
                    end
                    if (mem[i].qk && hit_k[i]) begin
                        mem[i].qk <= 1'b0;
                        mem[i].vk <= val_k[i];
                    end
                end
                if (enq) begin
                    mem[tail] <= incoming;
                    tail <= tail + 1'b1;
                end
                if (disp)
                    head <= head + 1'b1;
                count <= count + (AW+1)'(enq) - (AW+1)'(disp);
            end
        end
    end
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed vector table for streaming/backpressure plus hand sequences
// for wakeup, bypass, class routing, flush, reset and freeze.
module tb_issue_queue;
    import issue_queue_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in, dec_valid, dec_ready;
    logic [5:0]  dec_op;
    logic [4:0]  dec_rd;
    logic [31:0] dec_imm, dec_pc, dec_pred_pc, dec_vj, dec_vk;
    logic        dec_qj, dec_qk;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_val;
    logic        rob_avail, rs_avail, lsb_avail;
    logic [3:0]  rob_avail_pos, rs_avail_pos, lsb_avail_pos;
    logic        issue_valid, issue_qj, issue_qk, rob_push, rs_push, lsb_push, lock;
    logic [5:0]  issue_op;
    logic [4:0]  issue_rd;
    logic [31:0] issue_imm, issue_pc, issue_pred_pc, issue_vj, issue_vk;
    logic [3:0]  issue_robpos, issue_rspos, issue_lsbpos;

    int checks = 0;
    int errors = 0;

    issue_queue dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op), .dec_rd(dec_rd),
        .dec_imm(dec_imm), .dec_pc(dec_pc), .dec_pred_pc(dec_pred_pc),
        .dec_qj(dec_qj), .dec_qk(dec_qk), .dec_vj(dec_vj), .dec_vk(dec_vk),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .rob_avail(rob_avail), .rs_avail(rs_avail), .lsb_avail(lsb_avail),
        .rob_avail_pos(rob_avail_pos), .rs_avail_pos(rs_avail_pos), .lsb_avail_pos(lsb_avail_pos),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_rd(issue_rd), .issue_imm(issue_imm),
        .issue_pc(issue_pc), .issue_pred_pc(issue_pred_pc), .issue_vj(issue_vj), .issue_vk(issue_vk),
        .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_robpos(issue_robpos),
        .issue_rspos(issue_rspos), .issue_lsbpos(issue_lsbpos),
        .rob_push(rob_push), .rs_push(rs_push), .lsb_push(lsb_push), .lock(lock)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        dv;
        logic [5:0]  op;
        logic [31:0] imm;
        logic        ra;
        logic [3:0]  rpos;
        logic        e_rdy, e_iv;
        logic [5:0]  e_op;
        logic [31:0] e_imm;
        logic [3:0]  e_rpos;
        logic        e_lock, e_lsb;
    } vec_t;

    function automatic vec_t mk(int dv, int op, int imm, int ra, int rpos, int e_rdy, int e_iv,
                                int e_op, int e_imm, int e_rpos, int e_lock, int e_lsb);
        vec_t v;
        v.dv = 1'(dv); v.op = 6'(op); v.imm = 32'(imm); v.ra = 1'(ra); v.rpos = 4'(rpos);
        v.e_rdy = 1'(e_rdy); v.e_iv = 1'(e_iv); v.e_op = 6'(e_op); v.e_imm = 32'(e_imm);
        v.e_rpos = 4'(e_rpos); v.e_lock = 1'(e_lock); v.e_lsb = 1'(e_lsb);
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
        end
    endtask

    task automatic idle();
        rst_in = 0; rdy_in = 1; clear_in = 0; dec_valid = 0; dec_op = 0; dec_rd = 0;
        dec_imm = 0; dec_pc = 0; dec_pred_pc = 0; dec_qj = 0; dec_qk = 0; dec_vj = 0; dec_vk = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_val = 0; rob_avail = 1; rs_avail = 1; lsb_avail = 1;
        rob_avail_pos = 0; rs_avail_pos = 0; lsb_avail_pos = 0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Fill three entries while the ROB is blocked, then empty the queue with clear or reset.
    task automatic flush_case(input string n, input bit use_rst);
        for (int i = 0; i < 3; i++) begin
            idle(); rob_avail = 0; dec_valid = 1; dec_op = OP_ADDI; dec_imm = 32'(i + 1);
            settle(); tick();
        end
        idle(); dec_valid = 1; dec_op = OP_ADDI; dec_imm = 32'h42;
        if (use_rst) rst_in = 1; else clear_in = 1;
        settle();
        chk({n, "_iv_during"}, issue_valid, 0);
        chk({n, "_robpush_during"}, rob_push, 0);
        if (use_rst) chk({n, "_ready_during"}, dec_ready, 0);
        tick();
        idle(); dec_valid = 1; dec_op = OP_ADDI; dec_imm = 32'h99;
        settle();
        chk({n, "_iv_after"}, issue_valid, 0);
        chk({n, "_ready_after"}, dec_ready, 1);
        tick();
        idle(); settle();
        chk({n, "_iv_next"}, issue_valid, 1);
        chk({n, "_imm_next"}, issue_imm, 32'h99);
        tick();
        idle(); settle();
        chk({n, "_empty"}, issue_valid, 0);
        tick();
    endtask

    vec_t v [18];

    initial begin
        v[0]  = mk(1, OP_ADDI, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        v[1]  = mk(1, OP_ADDI, 2, 1, 4, 1, 1, OP_ADDI, 1, 4, 1, 0);
        v[2]  = mk(1, OP_ADDI, 3, 1, 5, 1, 1, OP_ADDI, 2, 5, 1, 0);
        v[3]  = mk(1, OP_ADDI, 4, 1, 6, 1, 1, OP_ADDI, 3, 6, 1, 0);
        v[4]  = mk(1, OP_ADDI, 5, 1, 7, 1, 1, OP_ADDI, 4, 7, 1, 0);
        v[5]  = mk(0, 0, 0, 1, 8, 1, 1, OP_ADDI, 5, 8, 1, 0);
        v[6]  = mk(0, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0);
        v[7]  = mk(1, OP_ADD, 11, 0, 2, 1, 0, 0, 0, 0, 0, 0);
        v[8]  = mk(1, OP_ADD, 12, 0, 2, 1, 0, 0, 0, 0, 0, 0);
        v[9]  = mk(1, OP_ADD, 13, 0, 2, 1, 0, 0, 0, 0, 0, 0);
        v[10] = mk(1, OP_ADD, 14, 0, 2, 1, 0, 0, 0, 0, 0, 0);
        v[11] = mk(1, OP_ADD, 15, 0, 2, 0, 0, 0, 0, 0, 0, 0);
        v[12] = mk(1, OP_ADD, 15, 1, 2, 0, 1, OP_ADD, 11, 2, 1, 0);
        v[13] = mk(1, OP_ADD, 15, 1, 2, 1, 1, OP_ADD, 12, 2, 1, 0);
        v[14] = mk(0, 0, 0, 1, 2, 1, 1, OP_ADD, 13, 2, 1, 0);
        v[15] = mk(0, 0, 0, 1, 2, 1, 1, OP_ADD, 14, 2, 1, 0);
        v[16] = mk(0, 0, 0, 1, 2, 1, 1, OP_ADD, 15, 2, 1, 0);
        v[17] = mk(0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0);

        idle(); rst_in = 1; dec_valid = 1;
        tick();
        settle();
        chk("rst_ready", dec_ready, 0);
        chk("rst_iv", issue_valid, 0);
        chk("rst_lock", lock, 0);
        tick();

        for (int i = 0; i < 18; i++) begin
            idle();
            dec_valid = v[i].dv; dec_op = v[i].op; dec_imm = v[i].imm;
            rob_avail = v[i].ra; rob_avail_pos = v[i].rpos;
            settle();
            chk($sformatf("v%0d_ready", i), dec_ready, v[i].e_rdy);
            chk($sformatf("v%0d_iv", i), issue_valid, v[i].e_iv);
            chk($sformatf("v%0d_robpush", i), rob_push, v[i].e_iv);
            chk($sformatf("v%0d_op", i), issue_op, v[i].e_op);
            chk($sformatf("v%0d_imm", i), issue_imm, v[i].e_imm);
            chk($sformatf("v%0d_robpos", i), issue_robpos, v[i].e_rpos);
            chk($sformatf("v%0d_lock", i), lock, v[i].e_lock);
            chk($sformatf("v%0d_lsbpush", i), lsb_push, v[i].e_lsb);
            tick();
        end

        // stored wakeup via channel 1, incoming bypass via channel 0
        idle(); rob_avail = 0; dec_valid = 1; dec_op = OP_ADD; dec_rd = 7; dec_pc = 32'h100;
        dec_qj = 1; dec_vj = 3; dec_vk = 32'h10;
        settle(); tick();
        idle(); rob_avail = 0; dec_valid = 1; dec_op = OP_SUB; dec_qj = 1; dec_vj = 5;
        dec_qk = 1; dec_vk = 9; cdb_valid = 2'b11; cdb_tag = {4'd3, 4'd5}; cdb_val = {32'h55, 32'h77};
        settle();
        chk("wake_hold_iv", issue_valid, 0);
        tick();
        idle(); settle();
        chk("wake_iv", issue_valid, 1);
        chk("wake_op", issue_op, OP_ADD);
        chk("wake_qj", issue_qj, 0);
        chk("wake_vj", issue_vj, 32'h55);
        chk("wake_vk", issue_vk, 32'h10);
        chk("wake_rd", issue_rd, 7);
        chk("wake_pc", issue_pc, 32'h100);
        tick();
        idle(); settle();
        chk("inbyp_op", issue_op, OP_SUB);
        chk("inbyp_qj", issue_qj, 0);
        chk("inbyp_vj", issue_vj, 32'h77);
        chk("nomatch_qk", issue_qk, 1);
        chk("nomatch_vk", issue_vk, 9);
        tick();
        idle(); settle();
        chk("wake_empty", issue_valid, 0);

        // head bypass during the dispatch cycle, both channels match: channel 0 wins
        idle(); dec_valid = 1; dec_op = OP_ADD; dec_qk = 1; dec_vk = 7; dec_vj = 1;
        settle(); tick();
        idle(); cdb_valid = 2'b11; cdb_tag = {4'd7, 4'd7}; cdb_val = {32'hCD, 32'hAB};
        settle();
        chk("hbyp_iv", issue_valid, 1);
        chk("hbyp_qk", issue_qk, 0);
        chk("hbyp_vk", issue_vk, 32'hAB);
        chk("hbyp_vj", issue_vj, 1);
        tick();

        // store waits for the LSB, then branch and load routing
        idle(); dec_valid = 1; dec_op = OP_SW;
        settle(); tick();
        idle(); lsb_avail = 0;
        settle();
        chk("sw_blocked_iv", issue_valid, 0);
        chk("sw_blocked_rs", rs_push, 0);
        tick();
        idle(); lsb_avail_pos = 6; rs_avail_pos = 9; dec_valid = 1; dec_op = OP_BEQ;
        settle();
        chk("sw_iv", issue_valid, 1);
        chk("sw_lsb", lsb_push, 1);
        chk("sw_rs", rs_push, 0);
        chk("sw_lock", lock, 0);
        chk("sw_lsbpos", issue_lsbpos, 6);
        chk("sw_rspos", issue_rspos, 9);
        tick();
        idle(); dec_valid = 1; dec_op = OP_LW;
        settle();
        chk("beq_op", issue_op, OP_BEQ);
        chk("beq_rs", rs_push, 1);
        chk("beq_lsb", lsb_push, 0);
        chk("beq_lock", lock, 0);
        tick();
        idle(); rs_avail = 0;
        settle();
        chk("lw_iv", issue_valid, 1);
        chk("lw_lsb", lsb_push, 1);
        chk("lw_rs", rs_push, 0);
        chk("lw_lock", lock, 1);
        tick();
        idle(); settle();
        chk("route_empty", issue_valid, 0);
        tick();

        flush_case("clear", 1'b0);
        flush_case("reset", 1'b1);

        // rdy_in=0: no enqueue on an empty queue
        idle(); rdy_in = 0; dec_valid = 1; dec_op = OP_ADDI; dec_imm = 32'h33;
        settle();
        chk("frz_ready", dec_ready, 0);
        chk("frz_iv", issue_valid, 0);
        tick();
        idle(); settle();
        chk("frz_dropped", issue_valid, 0);
        tick();
        // rdy_in=0: stored entry neither dispatches nor wakes up
        idle(); rob_avail = 0; dec_valid = 1; dec_op = OP_ADD; dec_qj = 1; dec_vj = 2;
        settle(); tick();
        idle(); rdy_in = 0; cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd2}; cdb_val = {32'h0, 32'hEE};
        settle();
        chk("frz_hold_iv", issue_valid, 0);
        tick();
        idle(); settle();
        chk("frz_resume_iv", issue_valid, 1);
        chk("frz_resume_qj", issue_qj, 1);
        chk("frz_resume_vj", issue_vj, 2);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
